// File: rtl/answer_tx_pkg.sv
// answer_tx_pkg: types and constants shared by the answer TX path.
//   state_t           - sequencer FSM states
//   ASCII_ZERO/LF     - character constants
//   digits_for_width  - decimal digits needed for the largest WIDTH-bit value
package answer_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV    = 3'd1,
        EMIT   = 3'd2,
        GUARD  = 3'd3,
        TERM   = 3'd4,
        GUARD2 = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // floor(width*log10(2)) + 1 digits hold 2^width-1 (log10(2) ~ 0.30103)
    function automatic int digits_for_width(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/answer_tx_sequencer_if.sv
// answer_tx_sequencer_if: answer input strobe plus UART TX byte handshake.
//   answer_valid/answer/ready          - answer word from the solver
//   output_en/output_data/output_busy  - byte strobe to the UART transmitter
// master = the sequencer, slave = solver/UART side.
interface answer_tx_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             answer_valid;
    logic [WIDTH-1:0] answer;
    logic             ready;
    logic             output_busy;
    logic             output_en;
    logic [7:0]       output_data;

    modport master (
        input  answer_valid, answer, output_busy,
        output ready, output_en, output_data
    );

    modport slave (
        output answer_valid, answer, output_busy,
        input  ready, output_en, output_data
    );
endinterface

// File: rtl/divmod10_iter.sv
// divmod10_iter: iterative restoring unsigned divide by 10, one quotient
// bit per cycle, WIDTH cycles per division.
//   clk, rst   - clock, synchronous active-high reset
//   start      - load dividend and begin (overrides a division in flight)
//   dividend   - value to divide
//   done       - high in the cycle the last step is computed
//   quotient   - valid while done is high
//   remainder  - valid while done is high
// Results come straight from the final step's combinational logic so the
// caller can chain the next division on the same edge with no idle cycle.
module divmod10_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [3:0]       remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q;     // dividend bits shift out, quotient bits shift in
    logic [3:0]       r;
    logic [CW-1:0]    cnt;
    logic [4:0]       trial;
    logic             ge;
    logic [4:0]       trial_sub;

    always_comb begin
        trial     = {r, q[WIDTH-1]};
        ge        = (trial >= 5'd10);
        trial_sub = ge ? (trial - 5'd10) : trial;
    end

    assign quotient  = {q[WIDTH-2:0], ge};
    assign remainder = trial_sub[3:0];
    assign done      = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            r   <= '0;
            cnt <= '0;
        end else if (start) begin
            q   <= dividend;
            r   <= '0;
            cnt <= CW'(WIDTH);
        end else if (cnt != '0) begin
            q   <= quotient;
            r   <= remainder;
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/answer_tx_sequencer.sv
// answer_tx_sequencer: converts one binary answer word to unsigned decimal
// ASCII and streams it MSD first, followed by TERMINATOR, to the UART.
//   clk, rst - clock, synchronous active-high reset
//   bus      - master side of answer_tx_sequencer_if (answer in, TX out)
// Digits are produced LSD first by repeated /10 and buffered, then replayed
// from the top of the buffer. Each sent byte is followed by a dead cycle so
// the transmitter has time to raise output_busy.
import answer_tx_pkg::*;

module answer_tx_sequencer #(
    parameter int         WIDTH      = 64,
    parameter int         DIGITS     = 20,
    parameter logic [7:0] TERMINATOR = ASCII_LF
) (
    input  logic                 clk,
    input  logic                 rst,
    answer_tx_sequencer_if.master bus
);
    // never smaller than the worst case, so the buffer cannot overflow
    localparam int MIN_DIGITS = digits_for_width(WIDTH);
    localparam int DEPTH      = (DIGITS > MIN_DIGITS) ? DIGITS : MIN_DIGITS;
    localparam int NW         = $clog2(DEPTH + 1);

    state_t           state;
    logic [NW-1:0]    n;
    logic [NW-1:0]    n_m1;
    logic [3:0]       digit [DEPTH];
    logic [7:0]       last_byte;
    logic [7:0]       tx_byte;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_q;
    logic [3:0]       div_r;

    assign n_m1 = n - NW'(1);

    // a non-zero quotient restarts the divider on the same edge it finishes
    assign div_start    = (state == IDLE && bus.answer_valid) ||
                          (state == DIV && div_done && div_q != '0);
    assign div_dividend = (state == IDLE) ? bus.answer : div_q;

    divmod10_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        tx_byte = TERMINATOR;
        if (state == EMIT)
            tx_byte = ASCII_ZERO + {4'h0, digit[n_m1]};
    end

    assign bus.ready       = (state == IDLE);
    assign bus.output_en   = (state == EMIT || state == TERM) && !bus.output_busy;
    // output_data only moves with a strobe; otherwise it shows the last byte
    assign bus.output_data = bus.output_en ? tx_byte : last_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            last_byte <= 8'h00;
        end else begin
            if (bus.output_en)
                last_byte <= tx_byte;
            case (state)
                IDLE: if (bus.answer_valid) begin
                    n     <= '0;
                    state <= DIV;
                end
                DIV: if (div_done) begin
                    digit[n] <= div_r;
                    n        <= n + NW'(1);
                    if (div_q == '0)
                        state <= EMIT;
                end
                EMIT: if (!bus.output_busy) begin
                    n     <= n_m1;
                    state <= GUARD;
                end
                GUARD:   state <= (n != '0) ? EMIT : TERM;
                TERM:    if (!bus.output_busy) state <= GUARD2;
                GUARD2:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_answer_tx_sequencer.sv
module tb_answer_tx_sequencer;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    answer_tx_sequencer_if #(.WIDTH(W)) bus ();

    answer_tx_sequencer #(.WIDTH(W), .DIGITS(20), .TERMINATOR(8'h0A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // UART busy model: busy for 'hold' cycles after each strobe, or forced
    int   hold       = 0;
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    assign bus.output_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)                busy_cnt <= 0;
        else if (bus.output_en) busy_cnt <= hold;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int   bytes_seen = 0;
    logic got_first  = 1'b0;
    int   first_cyc  = 0;
    int   acc_cyc    = 0;
    logic prev_en    = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.output_en) begin
                logic [7:0] e;
                tests++;
                if (bus.output_busy) begin
                    fails++;
                    $display("FAIL en_while_busy: output_en=1 with output_busy=1 at cycle %0d (want en=0)", cyc);
                end
                if (prev_en) begin
                    fails++;
                    $display("FAIL en_back_to_back: output_en high two cycles running at cycle %0d", cyc);
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%02h, want no byte", bus.output_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.output_data !== e) begin
                        fails++;
                        $display("FAIL tx_byte: got 0x%02h, want 0x%02h", bus.output_data, e);
                    end
                end
                bytes_seen++;
                if (!got_first) begin
                    got_first = 1'b1;
                    first_cyc = cyc;
                end
            end
            prev_en = bus.output_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic start_answer(input logic [63:0] v, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
        got_first  = 1'b0;
        bytes_seen = 0;
        @(posedge clk); #1;
        bus.answer       = v;
        bus.answer_valid = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        chk("ready_before_accept", 64'(bus.ready), 64'd1);
        @(posedge clk); #1;
        bus.answer_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_accept", 64'(bus.ready), 64'd0);
    endtask

    task automatic drain(input int limit, input string name);
        int k = 0;
        while ((exp_q.size() != 0 || !bus.ready) && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        tests++;
        if (k >= limit) begin
            fails++;
            $display("FAIL %s_timeout: %0d bytes outstanding ready=%0b, want 0 outstanding ready=1",
                     name, exp_q.size(), bus.ready);
        end
    endtask

    task automatic wait_bytes(input int nb, input int limit);
        int k = 0;
        while (bytes_seen < nb && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        tests++;
        if (k >= limit) begin
            fails++;
            $display("FAIL wait_bytes_timeout: saw %0d bytes, want %0d", bytes_seen, nb);
        end
    endtask

    typedef struct {
        logic [63:0] val;
        int          hold;
        string       txt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{64'd0,                    0,  "0"};
        vecs[1] = '{64'd12345,                10, "12345"};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  0,  "18446744073709551615"};
        vecs[3] = '{64'd9,                    2,  "9"};
        vecs[4] = '{64'd10,                   0,  "10"};
        vecs[5] = '{64'd1000,                 1,  "1000"};
        vecs[6] = '{64'd18446744073709551600, 3,  "18446744073709551600"};

        bus.answer_valid = 1'b0;
        bus.answer       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_en",    64'(bus.output_en), 64'd0);
        chk("reset_data",  64'(bus.output_data), 64'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            hold = vecs[i].hold;
            start_answer(vecs[i].val, vecs[i].txt);
            drain(4000, "vec");
            chk("byte_count", 64'(bytes_seen), 64'(vecs[i].txt.len() + 1));
            tests++;
            if (first_cyc - acc_cyc < vecs[i].txt.len() * W + 1) begin
                fails++;
                $display("FAIL latency: first byte %0d cycles after accept, want >= %0d",
                         first_cyc - acc_cyc, vecs[i].txt.len() * W + 1);
            end
        end

        // strobes while busy converting or emitting are ignored
        hold = 10;
        start_answer(64'd42, "42");
        repeat (10) @(posedge clk);
        #1 bus.answer = 64'd99; bus.answer_valid = 1'b1;
        @(posedge clk); #1 bus.answer_valid = 1'b0;
        wait_bytes(1, 500);
        repeat (3) @(posedge clk);
        #1 bus.answer = 64'd99; bus.answer_valid = 1'b1;
        @(posedge clk); #1 bus.answer_valid = 1'b0;
        drain(1000, "ignore_strobe");
        repeat (300) @(negedge clk);
        chk("ignore_strobe_bytes", 64'(bytes_seen), 64'd3);

        // reset mid-stream aborts, then a fresh answer works
        hold = 0;
        start_answer(64'd987654, "987654");
        wait_bytes(2, 1000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_en",    64'(bus.output_en), 64'd0);
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_data",  64'(bus.output_data), 64'h00);
        exp_q.delete();
        bytes_seen = 0;
        repeat (600) @(negedge clk);
        chk("abort_no_bytes", 64'(bytes_seen), 64'd0);
        start_answer(64'd7, "7");
        drain(500, "after_abort");
        chk("after_abort_bytes", 64'(bytes_seen), 64'd2);

        // long busy hold while a digit is waiting in EMIT
        force_busy = 1'b1;
        start_answer(64'd5, "5");
        repeat (70) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("hold_no_bytes", 64'(bytes_seen), 64'd0);
        @(posedge clk); #1 force_busy = 1'b0;
        @(negedge clk);
        chk("hold_release_en",   64'(bus.output_en), 64'd1);
        chk("hold_release_data", 64'(bus.output_data), 64'h35);
        drain(200, "hold");
        chk("hold_bytes", 64'(bytes_seen), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/answer_tx_sequencer.md
Name: answer_tx_sequencer

Overview:
- Sits between the puzzle solver core and the UART transmitter.
- Accepts one binary answer word with a strobe and converts it to unsigned decimal ASCII with an iterative divide-by-10.
- Streams the digits most-significant first, then a terminator byte, over the existing output_en / output_data / output_busy handshake.
- Owns the UART TX path: it sequences every byte and never issues a byte while the transmitter is busy.

Parameters:
- WIDTH, 64, bit width of the answer word.
- DIGITS, 20, digit buffer depth; must be at least ceil(WIDTH*log10(2)); 20 for WIDTH=64.
- TERMINATOR, 8'h0A, byte sent after the last digit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- answer_valid  input  1  one-cycle strobe; answer is sampled when this is high and ready is high.
- answer  input  WIDTH  unsigned answer value.
- ready  output  1  high when idle and able to accept an answer.
- output_busy  input  1  UART transmitter busy with the previous byte.
- output_en  output  1  one-cycle strobe: send output_data.
- output_data  output  8  byte to send.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: output_en=0, output_data=8'h00, ready=1, state=IDLE, digit count=0.
- Reset mid-operation: aborts immediately; no further bytes are sent and any partial number is dropped.

State machine:
- IDLE: ready=1.
  - On answer_valid, latch answer into the value register, clear digit count n, go to DIV. ready drops in the next cycle.
  - answer_valid while ready=0 is ignored, not queued.
- DIV: restoring division of the value by 10 takes exactly WIDTH cycles per digit.
  - Each cycle: shift the value MSB into a 4-bit remainder, conditionally subtract 10, shift the quotient bit in.
  - After WIDTH cycles: store the remainder at digit[n], n=n+1, value=quotient.
  - If the quotient is 0, go to EMIT; else repeat DIV.
  - Value 0 yields exactly one digit "0". No leading zeros are ever produced.
- EMIT:
  - When output_busy=0: output_en=1 for one cycle, output_data="0"+digit[n-1], n=n-1, go to GUARD.
  - When output_busy=1: output_en stays 0 and the state holds.
- GUARD: one dead cycle (output_en=0) so the transmitter can raise output_busy.
  - If n>0, go to EMIT.
  - Else go to TERM.
- TERM: when output_busy=0, send TERMINATOR with output_en=1 for one cycle, then go to GUARD2.
- GUARD2: one dead cycle, then IDLE.

Handshake and timing rules:
- output_en is never high for two consecutive cycles.
- output_en is never asserted in a cycle where output_busy=1.
- output_data holds its last value while output_en=0.
- Conversion latency is d*WIDTH cycles for a d-digit value; the first byte goes out no earlier than d*WIDTH+1 cycles after acceptance.
- Byte spacing is at least 2 cycles; otherwise it is set by output_busy.

Width rules:
- Remainder is 4 bits; its compare-and-subtract is 5 bits.
- The digit index is $clog2(DIGITS+1) bits.
- ASCII digit = 8'h30 + remainder.
- The maximum value 2^WIDTH-1 must fit in DIGITS digits; overflow of the digit buffer is unreachable by the parameter constraint.

Decomposition:
- Shared package answer_tx_pkg holds:
  - the state enum (IDLE, DIV, EMIT, GUARD, TERM, GUARD2);
  - ASCII constants ASCII_ZERO=8'h30 and ASCII_LF=8'h0A;
  - a digits_for_width() helper function.
- Sub-module divmod10_iter: iterative WIDTH-cycle unsigned divide by 10.
  - Ports: clk, rst, start, dividend, done, quotient, remainder.
  - The sequencer instantiates it once and handles digit buffering and the TX handshake itself.

Test Plan:
- answer=0, output_busy tied 0 -> exactly 2 bytes: 0x30, 0x0A; ready returns to 1 after GUARD2.
- answer=12345, busy model holds output_busy high 10 cycles after each output_en -> bytes 0x31,0x32,0x33,0x34,0x35,0x0A in order; output_en never high while busy.
- answer=2^64-1 -> 21 bytes "18446744073709551615\n"; first output_en no earlier than 20*64+1 cycles after acceptance.
- answer=42, then a second answer_valid with 99 pulsed during DIV and during EMIT -> output is only "42\n"; the second strobe has no effect.
- answer=987654; assert rst for 1 cycle after the 2nd byte is sent -> next cycle output_en=0, ready=1, no further bytes. Then answer=7 -> exactly "7\n".
- output_busy held high 200 cycles while in EMIT with answer=5 -> no output_en during the hold; 0x35 is sent the first cycle busy is low, then 0x0A.
